// File: rtl/game_flow_fsm_if.sv
// Handshake bundle between the game-flow controller and the rest of the level.
// The controller drives the master side; the level/top drives the slave side.
interface game_flow_fsm_if;
    logic       frame_tick;
    logic       start_key;
    logic       player1_dead;
    logic       player2_dead;
    logic       player1_at_door;
    logic       player2_at_door;
    logic [2:0] state;
    logic       level_reset;
    logic       freeze;
    logic [1:0] who_died;
    logic [9:0] timer_sec;
    logic       dead_flash;

    modport master (
        input  frame_tick, start_key, player1_dead, player2_dead,
               player1_at_door, player2_at_door,
        output state, level_reset, freeze, who_died, timer_sec, dead_flash
    );

    modport slave (
        output frame_tick, start_key, player1_dead, player2_dead,
               player1_at_door, player2_at_door,
        input  state, level_reset, freeze, who_died, timer_sec, dead_flash
    );
endinterface

// File: rtl/game_flow_fsm.sv
// Game-flow controller for one level: title, play, death animation, game over and win,
// plus the level_reset pulse, motion freeze and the HUD play timer.
module game_flow_fsm #(
    parameter int DEATH_FRAMES    = 90,
    parameter int WIN_HOLD_FRAMES = 30,
    parameter int FRAMES_PER_SEC  = 60,
    parameter int TIMER_MAX       = 999
) (
    input logic             Clk,
    input logic             Reset,
    game_flow_fsm_if.master bus
);
    typedef enum logic [2:0] {
        TITLE     = 3'd0,
        PLAYING   = 3'd1,
        DYING     = 3'd2,
        GAME_OVER = 3'd3,
        WIN       = 3'd4
    } state_t;

    localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
    localparam logic [7:0] WIN_LAST   = 8'(WIN_HOLD_FRAMES - 1);
    localparam logic [7:0] SEC_LAST   = 8'(FRAMES_PER_SEC - 1);
    localparam logic [9:0] TIMER_TOP  = 10'(TIMER_MAX);

    state_t     state;
    logic       level_reset;
    logic       start_q;
    logic [1:0] who_died;
    logic [9:0] timer_sec;
    logic [7:0] sub_cnt;
    logic [7:0] win_cnt;
    logic [7:0] death_cnt;

    logic start_edge;
    logic both_door;
    logic any_dead;

    assign start_edge = bus.start_key & ~start_q;
    assign both_door  = bus.player1_at_door & bus.player2_at_door;
    assign any_dead   = bus.player1_dead | bus.player2_dead;

    // Entering PLAYING clears the per-attempt counters at the same edge that raises
    // level_reset, so the HUD already shows zero during the pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= TITLE;
            level_reset <= 1'b0;
            start_q     <= 1'b0;
            who_died    <= 2'b00;
            timer_sec   <= 10'd0;
            sub_cnt     <= 8'd0;
            win_cnt     <= 8'd0;
            death_cnt   <= 8'd0;
        end else begin
            start_q     <= bus.start_key;
            level_reset <= 1'b0;
            case (state)
                TITLE, GAME_OVER: begin
                    if (start_edge) begin
                        state       <= PLAYING;
                        level_reset <= 1'b1;
                        timer_sec   <= 10'd0;
                        sub_cnt     <= 8'd0;
                        win_cnt     <= 8'd0;
                        who_died    <= 2'b00;
                    end
                end
                PLAYING: begin
                    if (bus.frame_tick) begin
                        if (sub_cnt == SEC_LAST) begin
                            sub_cnt <= 8'd0;
                            if (timer_sec < TIMER_TOP)
                                timer_sec <= timer_sec + 10'd1;
                        end else begin
                            sub_cnt <= sub_cnt + 8'd1;
                        end
                    end
                    if (!both_door)
                        win_cnt <= 8'd0;
                    else if (bus.frame_tick)
                        win_cnt <= win_cnt + 8'd1;
                    // Sticky death flags are stale while level_reset is still clearing them.
                    if (any_dead && !level_reset) begin
                        state     <= DYING;
                        who_died  <= {bus.player2_dead, bus.player1_dead};
                        death_cnt <= 8'd0;
                    end else if (bus.frame_tick && both_door && win_cnt == WIN_LAST) begin
                        state <= WIN;
                    end
                end
                DYING: begin
                    if (bus.frame_tick) begin
                        if (death_cnt == DEATH_LAST)
                            state <= GAME_OVER;
                        else
                            death_cnt <= death_cnt + 8'd1;
                    end
                end
                WIN: begin
                    if (start_edge)
                        state <= TITLE;
                end
                default: state <= TITLE;
            endcase
        end
    end

    assign bus.state       = state;
    assign bus.level_reset = level_reset;
    assign bus.freeze      = (state != PLAYING);
    assign bus.who_died    = who_died;
    assign bus.timer_sec   = timer_sec;
    assign bus.dead_flash  = (state == DYING) & death_cnt[3];
endmodule

// File: tb/tb_game_flow_fsm.sv
// Bench for game_flow_fsm: directed scenarios plus a randomized tail, all checked
// every cycle against a behavioural model of the game rules.
module tb_game_flow_fsm;
    localparam int DEATH   = 90;
    localparam int WINH    = 30;
    localparam int FPS     = 60;
    localparam int TMAX    = 999;
    localparam int SAT_FPS = 2;
    localparam int SAT_MAX = 7;

    logic Clk = 1'b0;
    logic Reset;
    logic frame_tick, start_key, p1_dead, p2_dead, p1_door, p2_door;

    always #5 Clk = ~Clk;

    game_flow_fsm_if bus ();
    game_flow_fsm_if sat_bus ();

    assign bus.frame_tick          = frame_tick;
    assign bus.start_key           = start_key;
    assign bus.player1_dead        = p1_dead;
    assign bus.player2_dead        = p2_dead;
    assign bus.player1_at_door     = p1_door;
    assign bus.player2_at_door     = p2_door;
    assign sat_bus.frame_tick      = frame_tick;
    assign sat_bus.start_key       = start_key;
    assign sat_bus.player1_dead    = p1_dead;
    assign sat_bus.player2_dead    = p2_dead;
    assign sat_bus.player1_at_door = p1_door;
    assign sat_bus.player2_at_door = p2_door;

    game_flow_fsm dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    // Same flow with a short second and low ceiling so timer saturation is reachable quickly.
    game_flow_fsm #(.FRAMES_PER_SEC(SAT_FPS), .TIMER_MAX(SAT_MAX)) dut_sat (
        .Clk(Clk), .Reset(Reset), .bus(sat_bus)
    );

    int checks = 0;
    int fails  = 0;

    // Model state: 0 TITLE, 1 PLAYING, 2 DYING, 3 GAME_OVER, 4 WIN
    int       m_state = 0;
    bit       m_lr = 1'b0;
    bit [1:0] m_who = 2'b00;
    int       play_ticks = 0;
    int       door_run = 0;
    int       dying_ticks = 0;
    bit       prev_key = 1'b0;

    function automatic int shown_time(input int ticks, input int fps, input int tmax);
        return (ticks / fps > tmax) ? tmax : ticks / fps;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic model_update();
        bit pressed;
        bit masked;
        if (Reset) begin
            m_state = 0; m_lr = 1'b0; m_who = 2'b00;
            play_ticks = 0; door_run = 0; dying_ticks = 0; prev_key = 1'b0;
            return;
        end
        pressed  = start_key && !prev_key;
        prev_key = start_key;
        masked   = m_lr;
        m_lr     = 1'b0;
        case (m_state)
            0, 3: if (pressed) begin
                m_state = 1; m_lr = 1'b1; play_ticks = 0; door_run = 0; m_who = 2'b00;
            end
            1: begin
                if (frame_tick) play_ticks++;
                if (p1_door && p2_door) begin
                    if (frame_tick) door_run++;
                end else begin
                    door_run = 0;
                end
                if ((p1_dead || p2_dead) && !masked) begin
                    m_state = 2; m_who = {p2_dead, p1_dead}; dying_ticks = 0;
                end else if (door_run == WINH) begin
                    m_state = 4;
                end
            end
            2: if (frame_tick) begin
                dying_ticks++;
                if (dying_ticks == DEATH) m_state = 3;
            end
            4: if (pressed) m_state = 0;
            default: m_state = 0;
        endcase
    endtask

    task automatic checkOutput();
        chk("state", bus.state, m_state);
        chk("level_reset", bus.level_reset, m_lr);
        chk("freeze", bus.freeze, m_state != 1);
        chk("who_died", bus.who_died, m_who);
        chk("timer_sec", bus.timer_sec, shown_time(play_ticks, FPS, TMAX));
        chk("dead_flash", bus.dead_flash, (m_state == 2) ? ((dying_ticks >> 3) & 1) : 0);
        chk("sat_state", sat_bus.state, m_state);
        chk("sat_timer_sec", sat_bus.timer_sec, shown_time(play_ticks, SAT_FPS, SAT_MAX));
    endtask

    task automatic applyStimulus();
        @(posedge Clk);
        model_update();
        #1;
        checkOutput();
    endtask

    initial begin
        Reset = 1'b1; frame_tick = 1'b0; start_key = 1'b0;
        p1_dead = 1'b0; p2_dead = 1'b0; p1_door = 1'b0; p2_door = 1'b0;
        applyStimulus();
        applyStimulus();
        Reset = 1'b0;
        applyStimulus();
        chk("reset_state", bus.state, 0);
        chk("reset_freeze", bus.freeze, 1);

        // Stale death flag present before the start press must be masked.
        p1_dead = 1'b1;
        applyStimulus();
        start_key = 1'b1;
        applyStimulus();
        start_key = 1'b0;
        chk("start_state", bus.state, 1);
        chk("start_level_reset", bus.level_reset, 1);
        chk("start_freeze", bus.freeze, 0);
        applyStimulus();
        p1_dead = 1'b0;
        chk("dead_masked", bus.state, 1);
        chk("pulse_one_cycle", bus.level_reset, 0);

        for (int i = 0; i < 150; i++) begin
            frame_tick = 1'($urandom_range(0, 1));
            p1_door    = 1'($urandom_range(0, 1));
            applyStimulus();
        end
        p1_door = 1'b0; frame_tick = 1'b0;
        p2_dead = 1'b1;
        applyStimulus();
        chk("p2_death_state", bus.state, 2);
        chk("p2_who_died", bus.who_died, 2'b10);

        for (int i = 0; i < DEATH - 1; i++) begin
            frame_tick = 1'b1; applyStimulus();
            frame_tick = 1'b0; applyStimulus();
        end
        chk("still_dying", bus.state, 2);
        start_key  = 1'b1;
        frame_tick = 1'b1;
        applyStimulus();
        frame_tick = 1'b0;
        chk("game_over", bus.state, 3);
        repeat (5) applyStimulus();
        chk("held_key_no_restart", bus.state, 3);
        start_key = 1'b0;
        applyStimulus();
        start_key = 1'b1;
        applyStimulus();
        start_key = 1'b0;
        chk("restart_state", bus.state, 1);
        chk("restart_level_reset", bus.level_reset, 1);
        applyStimulus();
        p2_dead = 1'b0;

        // Door hold broken after 29 ticks, then a clean run of 30.
        p1_door = 1'b1; p2_door = 1'b1; frame_tick = 1'b1;
        repeat (WINH - 1) applyStimulus();
        p2_door = 1'b0;
        applyStimulus();
        p2_door = 1'b1;
        repeat (WINH - 1) applyStimulus();
        chk("no_early_win", bus.state, 1);
        applyStimulus();
        chk("win", bus.state, 4);
        frame_tick = 1'b0; p1_door = 1'b0; p2_door = 1'b0;

        start_key = 1'b1;
        applyStimulus();
        start_key = 1'b0;
        chk("win_to_title", bus.state, 0);
        chk("win_no_pulse", bus.level_reset, 0);
        applyStimulus();
        start_key = 1'b1;
        applyStimulus();
        start_key = 1'b0;

        frame_tick = 1'b1;
        repeat (120) applyStimulus();
        chk("timer_two_sec", bus.timer_sec, 2);
        chk("timer_saturated", sat_bus.timer_sec, SAT_MAX);

        // Death and win on the same tick: death wins.
        p1_door = 1'b1; p2_door = 1'b1;
        repeat (WINH - 1) applyStimulus();
        p1_dead = 1'b1;
        applyStimulus();
        chk("death_over_win", bus.state, 2);
        chk("death_who_died", bus.who_died, 2'b01);
        p1_door = 1'b0; p2_door = 1'b0;
        repeat (20) applyStimulus();
        Reset = 1'b1;
        applyStimulus();
        chk("mid_dying_reset", bus.state, 0);
        chk("reset_timer", bus.timer_sec, 0);
        Reset = 1'b0; p1_dead = 1'b0; frame_tick = 1'b0;
        applyStimulus();

        for (int i = 0; i < 800; i++) begin
            Reset      = ($urandom_range(0, 299) == 0);
            frame_tick = ($urandom_range(0, 1) == 0);
            start_key  = ($urandom_range(0, 11) == 0);
            p1_dead    = ($urandom_range(0, 59) == 0);
            p2_dead    = ($urandom_range(0, 59) == 0);
            p1_door    = ($urandom_range(0, 39) != 0);
            p2_door    = ($urandom_range(0, 39) != 0);
            applyStimulus();
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/game_flow_fsm.md
# game_flow_fsm

Top-level game-flow controller for one level. It consumes the sticky per-player death flags from the water hazard stage and the per-player door flags, and sequences the game through title, play, death animation, game over and win. It issues the `level_reset` pulse that clears the hazard stage and player positions, freezes player motion outside active play, and keeps the elapsed play time for the HUD.

## Interface
Parameters:
- `DEATH_FRAMES`, default 90: frame ticks spent in DYING before GAME_OVER; range 1..255.
- `WIN_HOLD_FRAMES`, default 30: consecutive frame ticks both players must stay at their doors to win; range 1..255.
- `FRAMES_PER_SEC`, default 60: frame ticks per timer second; range 1..255.
- `TIMER_MAX`, default 999: saturation value of `timer_sec`.

Ports:
- `Clk`  in  1: system clock.
- `Reset`  in  1: synchronous, active-high reset.
- `frame_tick`  in  1: one-cycle pulse per video frame.
- `start_key`  in  1: level signal, high while the start key is held.
- `player1_dead`, `player2_dead`  in  1 each: sticky death flags from the hazard stage.
- `player1_at_door`, `player2_at_door`  in  1 each: player is inside its exit door.
- `state`  out  3: 0 TITLE, 1 PLAYING, 2 DYING, 3 GAME_OVER, 4 WIN.
- `level_reset`  out  1: one-cycle pulse. The top level ORs it into the hazard stage and player reset.
- `freeze`  out  1: high whenever `state` is not PLAYING.
- `who_died`  out  2: {p2, p1}, latched on entry to DYING.
- `timer_sec`  out  10: elapsed play seconds.
- `dead_flash`  out  1: blink control for the death animation.

## Operation
- Start edge: `start_key` is registered once. An edge is `start_key & ~start_key_q`. A key that is held produces exactly one edge.
- TITLE
  - Start edge: go to PLAYING. Assert `level_reset` in the first PLAYING cycle.
- PLAYING
  - If `player1_dead | player2_dead`: go to DYING, latch `who_died`, clear the frame counter.
  - Death takes priority over a win in the same cycle.
  - Dead inputs are ignored during the cycle `level_reset` is high. Stale sticky flags are still visible for that one cycle.
  - Win hold counter:
    - Increments on `frame_tick` while both `at_door` inputs are high.
    - Clears in any cycle where either `at_door` is low.
    - A `frame_tick` with counter == `WIN_HOLD_FRAMES-1` and both players at their doors moves to WIN.
  - Play timer:
    - A sub-counter counts `frame_tick` from 0 to `FRAMES_PER_SEC-1`.
    - On wrap, `timer_sec` increments, saturating at `TIMER_MAX`.
- DYING
  - The frame counter increments on `frame_tick`.
  - A `frame_tick` at counter == `DEATH_FRAMES-1` moves to GAME_OVER.
  - `dead_flash` = frame counter bit 3; it is 0 in all other states.
- GAME_OVER
  - Start edge: go to PLAYING with a `level_reset` pulse.
- WIN
  - Start edge: go to TITLE. No `level_reset` pulse.
- `level_reset` clears `timer_sec`, the sub-counter, the win counter and `who_died`.
- `timer_sec` holds its value in DYING, GAME_OVER and WIN, so the final time is displayed.
- In TITLE, `timer_sec` shows the last value; it clears on the next `level_reset`.
- `frame_tick` outside PLAYING and DYING has no effect.

## Timing
- Reset values:
  - `state` = TITLE, `freeze` = 1, `level_reset` = 0.
  - `who_died` = 0, `timer_sec` = 0, `dead_flash` = 0.
  - All counters 0, start edge register 0.
- `Reset` asserted mid-operation returns to TITLE on the next edge. `level_reset` is not pulsed during or after `Reset`.
- All outputs are registered (Moore); `freeze` is decoded from the registered `state`.
- Start edge in cycle N:
  - `state` = PLAYING and `level_reset` = 1 in cycle N+1.
  - `level_reset` = 0 in cycle N+2.
  - The hazard flags are clear by N+2.
- Death input high in cycle N (not masked): `state` = DYING and `freeze` = 1 in N+1.
- DYING lasts exactly `DEATH_FRAMES` frame ticks. GAME_OVER is entered the cycle after the last tick.
- Simultaneous sub-counter wrap and death: the second is counted, then DYING is entered.
- A start edge in PLAYING or DYING is ignored.

## Test plan
- Reset, then pulse `start_key` 1 cycle -> `state` 0→1 one cycle later, `level_reset` high for exactly 1 cycle, `freeze` 1→0.
- Hold `player1_dead`=1 from before the start edge, dropping it 1 cycle after `level_reset` -> stays PLAYING (mask works). Then raise `player2_dead` -> DYING next cycle, `who_died`=2'b10.
- In DYING with `DEATH_FRAMES`=90, give 89 ticks -> still DYING; `dead_flash` toggles every 8 ticks. Tick 90 -> GAME_OVER.
- Both `at_door` for 29 ticks, one drops for 1 cycle, then both held for 30 ticks -> WIN only after the second run of 30. With a death and a win on the same cycle -> DYING.
- 120 ticks of play -> `timer_sec`=2. Force near saturation -> holds at 999.
- Hold `start_key` high across GAME_OVER -> no restart until it is released and pressed again. Assert `Reset` mid-DYING -> TITLE, all outputs at their reset values.
